// File: rtl/execute_mc.sv
// execute_mc: LEGv8 execute stage with single-cycle ALU/branch paths, iterative MUL and an NZCV register.
// Latency: ALU/branch 0 cycles; MUL k+2 cycles (k = bit length of operand B), result in the DONE cycle.
// Backpressure: stall_E holds upstream while a MUL is issuing or iterating; flush_E kills EX and drops stall.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   valid_E, flush_E           instruction present / kill instruction in EX
//   AluSrc, AluControl         operand-B select, ALU operation
//   mulOp, setFlags            MUL instruction, flag-setting instruction
//   branchtoReg                BR: branch target taken from readData1_E
//   PC_E, signImm_E,
//   readData1_E..readData3_E   stage operands
//   PCBranch_E                 branch target
//   aluResult_E, zero_E        ALU result or MUL product, result-is-zero
//   writeData_E                store data
//   flags_E                    registered {N,Z,C,V}
//   stall_E                    EX holds, upstream must not advance
module execute_mc #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic [1:0]   AluSrc,
  input  logic [3:0]   AluControl,
  input  logic         mulOp,
  input  logic         setFlags,
  input  logic         branchtoReg,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic [N-1:0] readData3_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic [3:0]   flags_E,
  output logic         stall_E
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] mcand_q, mcand_d;
  logic [N-1:0] mplier_q, mplier_d;
  logic [N-1:0] acc_q, acc_d;
  logic [3:0]   flags_q, flags_d;

  // ---------------------------------------------------------------------------
  // Operand B mux and branch target
  // ---------------------------------------------------------------------------
  logic [N-1:0] src_b;

  always_comb begin
    src_b = readData3_E;
    case (AluSrc)
      2'b00:   src_b = readData2_E;
      2'b01:   src_b = signImm_E;
      default: src_b = readData3_E;
    endcase
  end

  assign PCBranch_E  = branchtoReg ? readData1_E : (PC_E + (signImm_E << 2));
  assign writeData_E = readData2_E;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU. ADD and SUB share one N+1-bit adder; SUB feeds ~B with
  // a carry-in of 1 so the carry out is the inverted borrow.
  // ---------------------------------------------------------------------------
  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic [N-1:0] alu_r;
  logic         alu_c;
  logic         alu_v;

  assign is_sub = (AluControl == 4'b0110);
  assign b_eff  = is_sub ? ~src_b : src_b;
  assign sum    = {1'b0, readData1_E} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (AluControl)
      4'b0000: alu_r = readData1_E & src_b;
      4'b0001: alu_r = readData1_E | src_b;
      4'b0010,
      4'b0110: begin
        alu_r = sum[N-1:0];
        alu_c = sum[N];
        // Overflow: both adder inputs share a sign that the result does not.
        alu_v = (readData1_E[N-1] == b_eff[N-1]) && (sum[N-1] != readData1_E[N-1]);
      end
      4'b0111: alu_r = src_b;
      4'b1100: alu_r = ~(readData1_E | src_b);
      default: alu_r = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier FSM
  // ---------------------------------------------------------------------------
  logic mul_start;
  logic flag_we;

  assign mul_start = valid_E && mulOp && !flush_E;

  // Flush overrides the stall in the same cycle so the bubble can be inserted.
  assign stall_E = ((state_q == S_IDLE) && mul_start) ||
                   ((state_q == S_BUSY) && !flush_E);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (flush_E) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_start) begin
            mcand_d  = readData1_E;
            mplier_d = src_b;
            acc_d    = '0;
            // A zero multiplier needs no iterations: go straight to DONE.
            state_d  = (src_b != '0) ? S_BUSY : S_DONE;
          end
        end
        S_BUSY: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          // Early termination once no set multiplier bits remain.
          if (mplier_d == '0) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result path and NZCV register
  // ---------------------------------------------------------------------------
  assign aluResult_E = (state_q == S_DONE) ? acc_q : alu_r;
  assign zero_E      = (aluResult_E == '0);

  // MUL is excluded explicitly: in its DONE cycle stall_E is low while the
  // MUL instruction (possibly with setFlags) is still presented.
  assign flag_we = valid_E && setFlags && !mulOp && !stall_E && !flush_E;

  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = {alu_r[N-1], (alu_r == '0), alu_c, alu_v};
    end
  end

  assign flags_E = flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: self-checking bench for execute_mc with a behavioural reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_execute_mc;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_E = 1'b0;
  logic         flush_E = 1'b0;
  logic [1:0]   AluSrc = 2'b00;
  logic [3:0]   AluControl = 4'b0000;
  logic         mulOp = 1'b0;
  logic         setFlags = 1'b0;
  logic         branchtoReg = 1'b0;
  logic [N-1:0] PC_E = '0;
  logic [N-1:0] signImm_E = '0;
  logic [N-1:0] readData1_E = '0;
  logic [N-1:0] readData2_E = '0;
  logic [N-1:0] readData3_E = '0;
  logic [N-1:0] PCBranch_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] writeData_E;
  logic         zero_E;
  logic [3:0]   flags_E;
  logic         stall_E;

  always #5 clk = ~clk;

  execute_mc #(.N(N)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
    .AluSrc(AluSrc), .AluControl(AluControl), .mulOp(mulOp),
    .setFlags(setFlags), .branchtoReg(branchtoReg), .PC_E(PC_E),
    .signImm_E(signImm_E), .readData1_E(readData1_E),
    .readData2_E(readData2_E), .readData3_E(readData3_E),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E),
    .writeData_E(writeData_E), .zero_E(zero_E), .flags_E(flags_E),
    .stall_E(stall_E)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: MUL tracked as phase + remaining iteration count with the
  // product computed directly; ALU uses plain arithmetic and comparisons.
  // ---------------------------------------------------------------------------
  int           m_phase = 0;   // 0 idle, 1 iterating, 2 result cycle
  int           m_left = 0;
  logic [N-1:0] m_prod = '0;
  logic [3:0]   m_flags = 4'b0000;

  function automatic logic [N-1:0] op_b();
    if (AluSrc == 2'b00) return readData2_E;
    if (AluSrc == 2'b01) return signImm_E;
    return readData3_E;
  endfunction

  function automatic void alu_ref(output logic [N-1:0] r, output logic c, output logic v);
    logic [N-1:0] a, b;
    a = readData1_E;
    b = op_b();
    r = '0; c = 1'b0; v = 1'b0;
    case (AluControl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        r = a + b;
        c = (r < a);
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'b0110: begin
        r = a - b;
        c = (a >= b);
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'b0111: r = b;
      4'b1100: r = ~(a | b);
      default: r = '0;
    endcase
  endfunction

  function automatic logic exp_stall();
    return !flush_E && ((m_phase == 0 && valid_E && mulOp) || m_phase == 1);
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] r, b;
    logic c, v, st;
    int k;
    if (reset) begin
      m_phase = 0; m_left = 0; m_prod = '0; m_flags = 4'b0000;
    end else begin
      alu_ref(r, c, v);
      st = exp_stall();
      if (valid_E && setFlags && !mulOp && !st && !flush_E)
        m_flags = {r[N-1], (r == '0), c, v};
      if (flush_E) m_phase = 0;
      else begin
        case (m_phase)
          0: if (valid_E && mulOp) begin
            b = op_b();
            m_prod = readData1_E * b;
            k = 0;
            for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
            if (k == 0) m_phase = 2;
            else begin m_phase = 1; m_left = k; end
          end
          1: begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] r, res, tgt;
    logic c, v;
    if (chk_en) begin
      alu_ref(r, c, v);
      res = (m_phase == 2) ? m_prod : r;
      tgt = branchtoReg ? readData1_E : PC_E + (signImm_E * 4);
      check("model_stall", stall_E, exp_stall());
      check("model_result", aluResult_E, res);
      check("model_zero", zero_E, res == '0);
      check("model_flags", flags_E, m_flags);
      check("model_pcbranch", PCBranch_E, tgt);
      check("model_writedata", writeData_E, readData2_E);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ---------------------------------------------------------------------------
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic run_mul(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_res, input int exp_stalls, input logic [3:0] exp_flags);
    int cnt;
    bit done;
    next();
    valid_E = 1'b1; mulOp = 1'b1; setFlags = 1'b1; AluSrc = 2'b00;
    AluControl = 4'b0010; readData1_E = a; readData2_E = b;
    cnt = 0; done = 1'b0;
    for (int i = 0; i < N + 10 && !done; i++) begin
      sample();
      if (stall_E) begin cnt++; next(); end
      else done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, stall_E, 1'b0);
    check({name, "_stalls"}, cnt, exp_stalls);
    check({name, "_res"}, aluResult_E, exp_res);
    check({name, "_zero"}, zero_E, exp_res == '0);
    next();
    valid_E = 1'b0; mulOp = 1'b0; setFlags = 1'b0;
    sample();
    check({name, "_idle_stall"}, stall_E, 1'b0);
    check({name, "_flags"}, flags_E, exp_flags);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    sample();
    check("reset_stall", stall_E, 1'b0);
    check("reset_flags", flags_E, 4'b0000);

    // ADD 5 + 7
    next();
    valid_E = 1'b1; AluControl = 4'b0010; AluSrc = 2'b01;
    readData1_E = 64'd5; signImm_E = 64'd7;
    sample();
    check("add_res", aluResult_E, 64'd12);
    check("add_zero", zero_E, 1'b0);
    check("add_stall", stall_E, 1'b0);

    // SUBS 3 - 3
    next();
    AluSrc = 2'b00; AluControl = 4'b0110; setFlags = 1'b1;
    readData1_E = 64'd3; readData2_E = 64'd3;
    sample();
    check("subs_res", aluResult_E, 64'd0);
    check("subs_zero", zero_E, 1'b1);
    next();
    valid_E = 1'b0; setFlags = 1'b0;
    sample();
    check("subs_flags", flags_E, 4'b0110);

    // SUBS 0 - 1
    next();
    valid_E = 1'b1; setFlags = 1'b1; readData1_E = 64'd0; readData2_E = 64'd1;
    sample();
    check("subs2_res", aluResult_E, 64'hFFFF_FFFF_FFFF_FFFF);
    next();
    valid_E = 1'b0; setFlags = 1'b0;
    sample();
    check("subs2_flags", flags_E, 4'b1000);

    // MULs (setFlags held high: flags must not move)
    run_mul("mul6x5", 64'd6, 64'd5, 64'd30, 4, 4'b1000);
    run_mul("mul6x0", 64'd6, 64'd0, 64'd0, 1, 4'b1000);
    run_mul("mulwrap", 64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, 3, 4'b1000);

    // Flush in the second BUSY cycle
    next();
    valid_E = 1'b1; mulOp = 1'b1; AluSrc = 2'b00; AluControl = 4'b0010;
    readData1_E = 64'd6; readData2_E = 64'd5;
    sample();
    check("flush_issue_stall", stall_E, 1'b1);
    next(); sample();
    check("flush_busy1_stall", stall_E, 1'b1);
    next();
    flush_E = 1'b1;
    sample();
    check("flush_stall", stall_E, 1'b0);
    next();
    flush_E = 1'b0; mulOp = 1'b0; AluSrc = 2'b01; setFlags = 1'b1;
    readData1_E = 64'h7FFF_FFFF_FFFF_FFFF; signImm_E = 64'd1;
    sample();
    check("post_flush_stall", stall_E, 1'b0);
    check("post_flush_res", aluResult_E, 64'h8000_0000_0000_0000);
    check("post_flush_flags_held", flags_E, 4'b1000);
    next();
    valid_E = 1'b0; setFlags = 1'b0;
    sample();
    check("adds_ovf_flags", flags_E, 4'b1001);

    // Reset in the middle of BUSY
    next();
    valid_E = 1'b1; mulOp = 1'b1; AluSrc = 2'b00; readData1_E = 64'd6; readData2_E = 64'd5;
    sample();
    next(); sample();
    check("rst_busy_stall", stall_E, 1'b1);
    next();
    reset = 1'b1; valid_E = 1'b0; mulOp = 1'b0;
    sample();
    next();
    reset = 1'b0;
    sample();
    check("rst_stall", stall_E, 1'b0);
    check("rst_flags", flags_E, 4'b0000);

    // Branch targets
    next();
    valid_E = 1'b1; branchtoReg = 1'b1; readData1_E = 64'h400;
    sample();
    check("br_target", PCBranch_E, 64'h400);
    next();
    branchtoReg = 1'b0; PC_E = 64'h100; signImm_E = 64'd4; readData2_E = 64'h55;
    sample();
    check("b_target", PCBranch_E, 64'h110);
    check("store_data", writeData_E, 64'h55);

    next();
    valid_E = 1'b0;
    sample();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
